// File: rtl/matrix_result_tx_pkg.sv
// Shared baud constants, FSM state type and divisor helper for the
// matrix result UART transmitter.
package matrix_result_tx_pkg;

   localparam logic [1:0] BAUD_4800   = 2'b00;
   localparam logic [1:0] BAUD_9600   = 2'b01;
   localparam logic [1:0] BAUD_19200  = 2'b10;
   localparam logic [1:0] BAUD_115200 = 2'b11;

   localparam int FRAME_BITS = 10;

   typedef enum logic [2:0] {IDLE, HDR, WAIT_WORD, SEND, FINISH} tx_state_t;

   // Clocks per bit, rounded to nearest.
   function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [1:0] sel);
      int unsigned baud;
      case (sel)
         BAUD_4800:  baud = 4800;
         BAUD_9600:  baud = 9600;
         BAUD_19200: baud = 19200;
         default:    baud = 115200;
      endcase
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/matrix_result_tx_uart_tx_byte.sv
// 8N1 byte transmitter: latches the byte and baud code at load, then shifts
// start, 8 data bits LSB first and stop bit. Accepts a new load on the last stop cycle.
module uart_tx_byte
   import matrix_result_tx_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] b_sel,
   input  logic       load,
   input  logic [7:0] data,
   output logic       ready,
   output logic       frame_done,
   output logic       tx
);

   localparam int CNT_W = $clog2(baud_div(CLK_HZ, BAUD_4800) + 1);
   localparam logic [CNT_W-1:0] DIV_4800   = CNT_W'(baud_div(CLK_HZ, BAUD_4800));
   localparam logic [CNT_W-1:0] DIV_9600   = CNT_W'(baud_div(CLK_HZ, BAUD_9600));
   localparam logic [CNT_W-1:0] DIV_19200  = CNT_W'(baud_div(CLK_HZ, BAUD_19200));
   localparam logic [CNT_W-1:0] DIV_115200 = CNT_W'(baud_div(CLK_HZ, BAUD_115200));
   localparam logic [3:0]       LAST_BIT   = 4'(FRAME_BITS - 1);

   logic             r_active;
   logic [CNT_W-1:0] r_div;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_bit;
   logic [8:0]       r_shift;
   logic             r_tx;
   logic [CNT_W-1:0] w_div;
   logic             w_bit_end;
   logic             w_last;

   always_comb begin
      w_div = DIV_115200;
      case (b_sel)
         BAUD_4800:  w_div = DIV_4800;
         BAUD_9600:  w_div = DIV_9600;
         BAUD_19200: w_div = DIV_19200;
         default:    w_div = DIV_115200;
      endcase
   end

   assign w_bit_end  = r_active && (r_cnt == r_div - CNT_W'(1));
   assign w_last     = w_bit_end && (r_bit == LAST_BIT);
   assign ready      = !r_active || w_last;
   assign frame_done = w_last;
   assign tx         = r_tx;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_active <= 1'b0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_shift  <= '1;
         r_tx     <= 1'b1;
      end else if (load && ready) begin
         r_active <= 1'b1;
         r_div    <= w_div;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_shift  <= {1'b1, data};
         r_tx     <= 1'b0;
      end else if (w_last) begin
         r_active <= 1'b0;
         r_tx     <= 1'b1;
      end else if (w_bit_end) begin
         r_cnt    <= '0;
         r_bit    <= r_bit + 4'd1;
         r_tx     <= r_shift[0];
         r_shift  <= {1'b1, r_shift[8:1]};
      end else if (r_active) begin
         r_cnt    <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/matrix_result_tx.sv
// Result transmit path: size header byte, then N*N words MSB byte first,
// each byte as an 8N1 frame through uart_tx_byte.
module matrix_result_tx
   import matrix_result_tx_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50000000,
   parameter int          WORD_BYTES = 3,
   parameter int          SIZE_W     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              b_sel,
   input  logic                    start,
   input  logic [SIZE_W-1:0]       size,
   input  logic [WORD_BYTES*8-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    tx,
   output logic                    busy,
   output logic                    done
);

   localparam int WORD_W = WORD_BYTES * 8;
   localparam int CNT_W  = 2 * SIZE_W;
   localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WORD_BYTES - 1);

   tx_state_t         r_state;
   logic [CNT_W-1:0]  r_count;
   logic [WORD_W-1:0] r_word;
   logic [IDX_W-1:0]  r_idx;
   logic              r_busy;
   logic              r_done;
   logic              r_in_ready;
   logic              w_load;
   logic              w_ready;
   logic              w_frame_done;
   logic [7:0]        w_byte;
   logic [IDX_W-1:0]  w_next_idx;
   logic [7:0]        w_word_byte [WORD_BYTES];

   genvar gi;
   generate
      for (gi = 0; gi < WORD_BYTES; gi++) begin : g_bytes
         assign w_word_byte[gi] = r_word[8*gi +: 8];
      end
   endgenerate

   assign w_next_idx = r_idx - IDX_W'(1);

   // Loads are issued combinationally so each frame starts on the same edge
   // that accepts start, the word handshake, or the previous stop bit.
   always_comb begin
      w_load = 1'b0;
      w_byte = 8'h00;
      case (r_state)
         IDLE: if (start && w_ready) begin
            w_load = 1'b1;
            w_byte = 8'(size);
         end
         WAIT_WORD: if (in_valid && r_in_ready) begin
            w_load = 1'b1;
            w_byte = in_data[WORD_W-1 -: 8];
         end
         SEND: if (w_frame_done && (r_idx != '0)) begin
            w_load = 1'b1;
            w_byte = w_word_byte[w_next_idx];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_count    <= '0;
         r_word     <= '0;
         r_idx      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_in_ready <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (start && w_ready) begin
               r_count <= CNT_W'(size) * CNT_W'(size);
               r_busy  <= 1'b1;
               r_state <= HDR;
            end
            HDR: if (w_frame_done) begin
               if (r_count == '0) begin
                  r_done  <= 1'b1;
                  r_state <= FINISH;
               end else begin
                  r_in_ready <= 1'b1;
                  r_state    <= WAIT_WORD;
               end
            end
            WAIT_WORD: if (in_valid && r_in_ready) begin
               r_word     <= in_data;
               r_idx      <= TOP_IDX;
               r_in_ready <= 1'b0;
               r_state    <= SEND;
            end
            SEND: if (w_frame_done) begin
               if (r_idx != '0) begin
                  r_idx <= w_next_idx;
               end else begin
                  r_count <= r_count - CNT_W'(1);
                  if (r_count == CNT_W'(1)) begin
                     r_done  <= 1'b1;
                     r_state <= FINISH;
                  end else begin
                     r_in_ready <= 1'b1;
                     r_state    <= WAIT_WORD;
                  end
               end
            end
            FINISH: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLK_HZ(CLK_HZ)
   ) u_tx (
      .clk       (clk),
      .rst       (rst),
      .b_sel     (b_sel),
      .load      (w_load),
      .data      (w_byte),
      .ready     (w_ready),
      .frame_done(w_frame_done),
      .tx        (tx)
   );

   assign busy     = r_busy;
   assign done     = r_done;
   assign in_ready = r_in_ready;

endmodule

// File: tb/tb_matrix_result_tx.sv
// Bench for matrix_result_tx: frame-timeline model checked every cycle,
// plus literal byte sequences and done-timing expectations per scenario.
`timescale 1ns/1ps
module tb_matrix_result_tx;

   // 460800 Hz gives divisors 96/48/24/4, keeping frames short.
   localparam int unsigned TB_CLK_HZ = 460800;
   localparam int LIMIT = 20000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  b_sel = 2'b01;
   logic        start = 1'b0;
   logic [3:0]  size = 4'd0;
   logic [23:0] in_data = 24'd0;
   logic        in_valid = 1'b0;
   logic        in_ready, tx, busy, done;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int done_cnt = 0;
   int in_ready_seen = 0;
   bit chk_en = 1'b0;

   matrix_result_tx #(
      .CLK_HZ(TB_CLK_HZ), .WORD_BYTES(3), .SIZE_W(4)
   ) dut (
      .clk(clk), .rst(rst), .b_sel(b_sel), .start(start), .size(size),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- model: timeline of frames ----------------
   bit          m_busy = 0, m_done = 0, m_wait = 0, m_act = 0;
   int          m_t = 0, m_div = 1, m_words = 0;
   logic [7:0]  m_byte = 8'h00;
   logic [7:0]  m_q[$];
   logic [7:0]  frame_log[$];

   function automatic int tb_div(input logic [1:0] s);
      case (s)
         2'b00:   return 96;
         2'b01:   return 48;
         2'b10:   return 24;
         default: return 4;
      endcase
   endfunction

   task automatic m_begin(input logic [7:0] b);
      m_act = 1; m_t = 0; m_byte = b; m_div = tb_div(b_sel);
      frame_log.push_back(b);
   endtask

   function automatic logic exp_tx();
      int k;
      if (!m_act) return 1'b1;
      k = m_t / m_div;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_byte[k-1];
      return 1'b1;
   endfunction

   task automatic model_step();
      bit idle;
      bit ended;
      idle = !m_busy;
      ended = 0;
      if (m_done) begin m_done = 0; m_busy = 0; end
      if (m_act) begin
         m_t++;
         if (m_t == 10 * m_div) begin m_act = 0; ended = 1; end
      end
      if (ended) begin
         if (m_q.size() > 0) m_begin(m_q.pop_front());
         else if (m_words == 0) m_done = 1;
         else m_wait = 1;
      end else if (m_wait && in_valid) begin
         m_wait = 0;
         m_words--;
         m_begin(in_data[23:16]);
         m_q.push_back(in_data[15:8]);
         m_q.push_back(in_data[7:0]);
      end else if (idle && start) begin
         m_busy = 1;
         m_words = int'(size) * int'(size);
         m_begin({4'h0, size});
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_busy = 0; m_done = 0; m_wait = 0; m_act = 0; m_q.delete();
      end else begin
         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check($sformatf("outputs@%0d", cyc), {tx, busy, done, in_ready},
               {exp_tx(), m_busy, m_done, m_wait});
         if (done) done_cnt++;
         if (in_ready) in_ready_seen++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_start(input logic [3:0] n, output int s);
      @(negedge clk);
      size = n; start = 1'b1; s = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int s, input int exp_off);
      int n = 0;
      while (!done && n < LIMIT) begin @(negedge clk); n++; end
      if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
      else if (exp_off >= 0) check(name, 32'(cyc - s), 32'(exp_off));
   endtask

   task automatic present_word(input logic [23:0] w);
      int n = 0;
      in_valid = 1'b1; in_data = w;
      while (!in_ready && n < LIMIT) begin @(negedge clk); n++; end
      if (!in_ready) begin
         check("handshake_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 24'($urandom);
      check($sformatf("word_%06h_frame_start", w), 32'(tx), 32'd0);
   endtask

   task automatic check_log(input string name, input logic [7:0] exp[$]);
      check({name, "_frames"}, 32'(frame_log.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < frame_log.size(); i++)
         check($sformatf("%s_byte%0d", name, i), 32'(frame_log[i]), 32'(exp[i]));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, s2, d0, r0;
      logic [7:0] e[$];

      check("div_4800",   matrix_result_tx_pkg::baud_div(32'd50000000, 2'b00), 32'd10417);
      check("div_9600",   matrix_result_tx_pkg::baud_div(32'd50000000, 2'b01), 32'd5208);
      check("div_19200",  matrix_result_tx_pkg::baud_div(32'd50000000, 2'b10), 32'd2604);
      check("div_115200", matrix_result_tx_pkg::baud_div(32'd50000000, 2'b11), 32'd434);

      #3 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", {tx, busy, done, in_ready}, 4'b1000);
      chk_en = 1'b1;
      #2 rst = 1'b1;

      // N=0: header only
      b_sel = 2'b01; frame_log.delete(); d0 = done_cnt; r0 = in_ready_seen;
      do_start(4'd0, s);
      check("n0_hdr_start", 32'(tx), 32'd0);
      wait_done("n0_done_offset", s, 481);
      repeat (3) @(negedge clk);
      e = '{8'h00};
      check_log("n0", e);
      check("n0_done_pulses", 32'(done_cnt - d0), 32'd1);
      check("n0_in_ready_never", 32'(in_ready_seen - r0), 32'd0);

      // N=2: four words back to back
      frame_log.delete(); d0 = done_cnt;
      do_start(4'd2, s);
      present_word(24'h000013);
      present_word(24'h000016);
      present_word(24'h00002B);
      present_word(24'h000032);
      wait_done("n2_done_offset", s, 1 + 13 * 480 + 4);
      repeat (3) @(negedge clk);
      e = '{8'h02, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h16,
            8'h00, 8'h00, 8'h2B, 8'h00, 8'h00, 8'h32};
      check_log("n2", e);
      check("n2_done_pulses", 32'(done_cnt - d0), 32'd1);

      // stall in WAIT_WORD
      frame_log.delete();
      do_start(4'd1, s);
      for (int n = 0; n < LIMIT && !in_ready; n++) @(negedge clk);
      repeat (2000) @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd1);
      check("stall_tx_idle", 32'(tx), 32'd1);
      present_word(24'hA5C30F);
      wait_done("stall_done", s, -1);
      repeat (3) @(negedge clk);
      e = '{8'h01, 8'hA5, 8'hC3, 8'h0F};
      check_log("stall", e);

      // baud change mid header
      frame_log.delete(); b_sel = 2'b01;
      do_start(4'd1, s);
      repeat (240) @(negedge clk);
      b_sel = 2'b11;
      present_word(24'h0102FF);
      wait_done("baudchg_done_offset", s, 1 + 480 + 1 + 3 * 40);
      repeat (3) @(negedge clk);
      e = '{8'h01, 8'h01, 8'h02, 8'hFF};
      check_log("baudchg", e);

      // reset in the middle of the second frame
      b_sel = 2'b01; d0 = done_cnt;
      do_start(4'd1, s);
      present_word(24'hDEAD01);
      repeat (300) @(negedge clk);
      check("pre_reset_tx_low", 32'(tx), 32'd0);
      #2 rst = 1'b0;
      #1 check("async_reset", {tx, busy, done, in_ready}, 4'b1000);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      check("aborted_no_done", 32'(done_cnt - d0), 32'd0);
      frame_log.delete();
      do_start(4'd1, s);
      check("post_reset_hdr_start", 32'(tx), 32'd0);
      present_word(24'h123456);
      wait_done("post_reset_done_offset", s, 1 + 480 + 1 + 1440);
      repeat (3) @(negedge clk);
      e = '{8'h01, 8'h12, 8'h34, 8'h56};
      check_log("post_reset", e);

      // start while busy and start coinciding with done are ignored
      b_sel = 2'b11; frame_log.delete(); d0 = done_cnt;
      do_start(4'd1, s);
      repeat (10) @(negedge clk);
      do_start(4'd3, s2);
      present_word(24'h7E8001);
      wait_done("busy_start_done", s, -1);
      size = 4'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (100) @(negedge clk);
      check("busy_start_idle", 32'(busy), 32'd0);
      e = '{8'h01, 8'h7E, 8'h80, 8'h01};
      check_log("busy_start", e);
      check("busy_start_done_pulses", 32'(done_cnt - d0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
